// File: rtl/music_box_pkg.sv
// music_box_pkg: shared constants for the music-box audio path (note table,
// melody ROM contents, counter widths and FSM states).
package music_box_pkg;

    localparam int unsigned CODE_W     = 5;
    localparam int unsigned CNT_W      = 24;
    localparam int unsigned NOTE_COUNT = 25;

    // Semitones C4..B5 in Hz x100, truncated; entry 0 is the rest code.
    localparam int unsigned FREQ_X100 [NOTE_COUNT] = '{
        0,
        26162, 27718, 29366, 31112, 32962, 34922,
        36999, 39199, 41530, 44000, 46616, 49388,
        52325, 55436, 58732, 62225, 65925, 69845,
        73998, 78399, 83060, 88000, 93232, 98776
    };

    localparam logic [CODE_W-1:0] MELODY [NOTE_COUNT] = '{
        5'd10, 5'd10, 5'd12, 5'd10, 5'd15, 5'd14, 5'd0,
        5'd10, 5'd10, 5'd12, 5'd10, 5'd17, 5'd15, 5'd0,
        5'd10, 5'd10, 5'd22, 5'd19, 5'd15, 5'd14, 5'd12,
        5'd0,  5'd20, 5'd19, 5'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2,
        ST_REST = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] half_period(
        input int unsigned       clk_hz,
        input logic [CODE_W-1:0] code
    );
        longint unsigned num;
        longint unsigned den;
        if (code == '0 || code >= CODE_W'(NOTE_COUNT)) return '0;
        num = 64'(clk_hz) * 64'd100;
        den = 64'd2 * 64'(FREQ_X100[code]);
        return CNT_W'(num / den);
    endfunction

endpackage

// File: rtl/melodia_rom.sv
// melodia_rom: combinational note-address to melody-code lookup; out-of-range
// addresses read as the rest code.
module melodia_rom
    import music_box_pkg::*;
#(
    parameter int unsigned NUM_NOTES = NOTE_COUNT
) (
    input  logic [CODE_W-1:0] addr_i,
    output logic [CODE_W-1:0] code_o
);

    logic in_range;

    assign in_range = (32'(addr_i) < NUM_NOTES) && (32'(addr_i) < NOTE_COUNT);
    assign code_o   = in_range ? MELODY[addr_i] : '0;

endmodule

// File: rtl/nota_a_tono.sv
// nota_a_tono: turns the sequencer note address into a square wave, inserting
// a silent articulation gap at the start of every note.
module nota_a_tono
    import music_box_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned GAP_CYCLES = 120_000,
    parameter int unsigned NUM_NOTES  = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CODE_W-1:0] direccion_nota,
    output logic              audio_out,
    output logic [CODE_W-1:0] note_code,
    output logic              playing
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              audio_q, audio_d;
    logic              playing_q, playing_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] addr_q;
    logic              first_q;
    logic              change;
    logic [CODE_W-1:0] rom_code;
    logic [CNT_W-1:0]  half;
    logic [CNT_W-1:0]  half_tab [NOTE_COUNT];

    melodia_rom #(.NUM_NOTES(NUM_NOTES)) u_rom (
        .addr_i (direccion_nota),
        .code_o (rom_code)
    );

    // Half-periods are elaboration-time constants, so this is just a ROM.
    for (genvar g = 0; g < NOTE_COUNT; g++) begin : g_half
        assign half_tab[g] = half_period(CLK_HZ, CODE_W'(g));
    end

    assign half   = half_tab[code_q];
    assign change = first_q || (direccion_nota != addr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        audio_d = audio_q;
        code_d  = code_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            audio_d = 1'b0;
        end else if (change) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            audio_d = 1'b0;
            code_d  = rom_code;
        end else begin
            case (state_q)
                ST_GAP: begin
                    state_d = (cnt_q == GAP_LAST) ? ((code_q != '0) ? ST_PLAY : ST_REST) : ST_GAP;
                    cnt_d   = (cnt_q == GAP_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                ST_PLAY: begin
                    audio_d = (cnt_q == half - CNT_W'(1)) ? ~audio_q : audio_q;
                    cnt_d   = (cnt_q == half - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
        playing_d = (state_d == ST_PLAY);
    end

    // Leaving enable low keeps the first-cycle flag armed so re-enabling restarts the note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            audio_q   <= 1'b0;
            playing_q <= 1'b0;
            code_q    <= '0;
            addr_q    <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            audio_q   <= audio_d;
            playing_q <= playing_d;
            code_q    <= code_d;
            addr_q    <= direccion_nota;
            first_q   <= !enable;
        end
    end

    assign audio_out = audio_q;
    assign note_code = code_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_nota_a_tono.sv
// tb_nota_a_tono: scoreboard bench; expected output edges are queued with the
// stimulus and matched against observed edges of audio_out and playing.
module tb_nota_a_tono;

    localparam int G   = 100;
    localparam int H10 = 13_636;
    localparam int H1  = 22_934;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b1;
    logic [4:0] direccion_nota = 5'd0;
    logic       audio_out;
    logic       playing;
    logic [4:0] note_code;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  aq[$];
    ev_t  pq[$];
    ev_t  ea, ep;
    logic aud_prev = 1'b0;
    logic play_prev = 1'b0;

    nota_a_tono #(
        .CLK_HZ     (12_000_000),
        .GAP_CYCLES (G),
        .NUM_NOTES  (25)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .direccion_nota (direccion_nota),
        .audio_out      (audio_out),
        .note_code      (note_code),
        .playing        (playing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ev_t ev(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((aq.size() + pq.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(aq.size() + pq.size()), 0);
    endtask

    always @(negedge clk) begin
        if (audio_out !== aud_prev) begin
            if (aq.size() == 0) check("audio_unexpected_edge", 32'(audio_out), 32'(aud_prev));
            else begin
                ea = aq.pop_front();
                check("audio_edge_cycle", 32'(cyc), 32'(ea.cyc));
                check("audio_edge_value", 32'(audio_out), 32'(ea.val));
            end
        end
        if (playing !== play_prev) begin
            if (pq.size() == 0) check("playing_unexpected_edge", 32'(playing), 32'(play_prev));
            else begin
                ep = pq.pop_front();
                check("playing_edge_cycle", 32'(cyc), 32'(ep.cyc));
                check("playing_edge_value", 32'(playing), 32'(ep.val));
            end
        end
        aud_prev  = audio_out;
        play_prev = playing;
    end

    initial begin
        int c;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_audio", 32'(audio_out), 0);
        check("rst_code", 32'(note_code), 0);
        check("rst_playing", 32'(playing), 0);

        // A4 straight out of reset
        @(negedge clk);
        c = cyc;
        rst_n = 1'b1;
        pq.push_back(ev(c + 1 + G, 1'b1));
        aq.push_back(ev(c + 1 + G + H10, 1'b1));
        repeat (3) @(negedge clk);
        check("a4_code", 32'(note_code), 10);
        drain("a4_first_rise", 20_000);

        // enable low for 50 cycles mid-note, then a full gap and three toggles
        @(negedge clk);
        c = cyc;
        enable = 1'b0;
        aq.push_back(ev(c + 1, 1'b0));
        pq.push_back(ev(c + 1, 1'b0));
        repeat (50) @(negedge clk);
        c = cyc;
        enable = 1'b1;
        pq.push_back(ev(c + 1 + G, 1'b1));
        aq.push_back(ev(c + 1 + G + H10, 1'b1));
        aq.push_back(ev(c + 1 + G + 2 * H10, 1'b0));
        aq.push_back(ev(c + 1 + G + 3 * H10, 1'b1));
        drain("reenable_toggles", 50_000);

        // change to C4 while audio is high
        @(negedge clk);
        c = cyc;
        direccion_nota = 5'd24;
        aq.push_back(ev(c + 1, 1'b0));
        pq.push_back(ev(c + 1, 1'b0));
        pq.push_back(ev(c + 1 + G, 1'b1));
        aq.push_back(ev(c + 1 + G + H1, 1'b1));
        repeat (2) @(negedge clk);
        check("c4_code", 32'(note_code), 1);
        repeat (48) @(negedge clk);
        check("c4_gap_silent", 32'(audio_out), 0);
        drain("c4_first_rise", 30_000);

        // asynchronous reset between edges while playing
        @(negedge clk);
        c = cyc;
        aq.push_back(ev(c + 1, 1'b0));
        pq.push_back(ev(c + 1, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_audio", 32'(audio_out), 0);
        check("async_rst_code", 32'(note_code), 0);
        check("async_rst_playing", 32'(playing), 0);
        repeat (2) @(negedge clk);

        // rest code, then out-of-range address
        direccion_nota = 5'd6;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("rest_code", 32'(note_code), 0);
        check("rest_playing", 32'(playing), 0);
        check("rest_audio", 32'(audio_out), 0);
        direccion_nota = 5'd30;
        repeat (200) @(negedge clk);
        check("oor_code", 32'(note_code), 0);
        check("oor_playing", 32'(playing), 0);
        check("oor_audio", 32'(audio_out), 0);

        // changes every 60 cycles never let the gap finish
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            c = cyc;
            direccion_nota = (i % 2 == 1) ? 5'd24 : 5'd0;
            repeat (2) @(negedge clk);
            check("rapid_code", 32'(note_code), (i % 2 == 1) ? 32'd1 : 32'd10);
            repeat (57) @(negedge clk);
            check("rapid_playing", 32'(playing), 0);
        end
        pq.push_back(ev(c + 1 + G, 1'b1));
        drain("rapid_final_play", 300);
        check("rapid_audio", 32'(audio_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
